// File: rtl/frame_write_arbiter.sv
// frame_write_arbiter
//   Shares the single write port of the character frame buffer between N
//   drawing engines. Arbitration is round-robin. The winner keeps the port
//   until its burst ends: a beat with last=1, a dropped request, or
//   MAX_BURST accepted beats. The frame write bus is registered, so a write
//   appears one cycle after the beat is accepted. Beats whose coordinates
//   lie off-screen are still accepted but are not written; range_err flags
//   them instead.
//
//   Optional feature, enabled by defining FRAME_ARB_CLEAR_EN:
//   a clear sequencer writes BLANK_CHAR to every cell in scan order, after
//   reset and on clear_start.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   req[N]            requester i presents a valid beat
//   last[N]           requester i's beat is the final beat of its burst
//   x_in/y_in/char_in 6 bits per requester, lane i at [6i+5:6i]
//   grant[N]          beat from i accepted this cycle (req & grant = transfer)
//   frame_x/y/char    registered write address and glyph
//   frame_we          registered write strobe
//   busy              arbiter not idle
//   range_err         one-cycle pulse, aligned with where frame_we would be,
//                     for an accepted off-screen beat
//   clear_start       (FRAME_ARB_CLEAR_EN) request a full-screen clear
//   clear_done        (FRAME_ARB_CLEAR_EN) pulse alongside the last clear write
module frame_write_arbiter #(
   parameter int          N          = 3,
   parameter int          COLS       = 40,
   parameter int          ROWS       = 30,
   parameter int          MAX_BURST  = 64,
   parameter logic [5:0]  BLANK_CHAR = 6'd0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N-1:0]    req,
   input  logic [N-1:0]    last,
   input  logic [6*N-1:0]  x_in,
   input  logic [6*N-1:0]  y_in,
   input  logic [6*N-1:0]  char_in,
   output logic [N-1:0]    grant,
   output logic [5:0]      frame_x,
   output logic [5:0]      frame_y,
   output logic [5:0]      frame_char,
   output logic            frame_we,
   output logic            busy,
   output logic            range_err
`ifdef FRAME_ARB_CLEAR_EN
   ,
   input  logic            clear_start,
   output logic            clear_done
`endif
);

   localparam int               PW         = (N > 1) ? $clog2(N) : 1;
   localparam logic [PW-1:0]    LAST_OWNER = PW'(N - 1);
   localparam logic [6:0]       COLS_L     = 7'(COLS);
   localparam logic [6:0]       ROWS_L     = 7'(ROWS);
   localparam logic [7:0]       MAX_B      = 8'(MAX_BURST);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOCK  = 2'd1,
      S_CLEAR = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   owner_q, owner_d;
   logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [7:0]      beat_cnt_q, beat_cnt_d;
   logic [5:0]      frame_x_q, frame_x_d;
   logic [5:0]      frame_y_q, frame_y_d;
   logic [5:0]      frame_char_q, frame_char_d;
   logic            frame_we_q, frame_we_d;
   logic            range_err_q, range_err_d;

   logic            sel_req, sel_last;
   logic [5:0]      sel_x, sel_y, sel_char;
   logic [PW-1:0]   pick, pick_lo, pick_hi, next_rr;
   logic            pick_valid, found_hi;
   logic            in_range, clear_go;
   logic [N-1:0]    grant_s;

`ifdef FRAME_ARB_CLEAR_EN
   localparam logic [5:0] LAST_X = 6'(COLS - 1);
   localparam logic [5:0] LAST_Y = 6'(ROWS - 1);
   logic [5:0]      clr_x_q, clr_x_d;
   logic [5:0]      clr_y_q, clr_y_d;
   logic            clr_pend_q, clr_pend_d;
   logic            clear_done_q, clear_done_d;
   logic            clr_last;
`endif

   // Lane mux: pick the current owner's request and beat fields.
   always_comb begin
      sel_req  = 1'b0;
      sel_last = 1'b0;
      sel_x    = 6'd0;
      sel_y    = 6'd0;
      sel_char = 6'd0;
      for (int i = 0; i < N; i++) begin
         sel_req  = sel_req  | (req[i]  & (owner_q == PW'(i)));
         sel_last = sel_last | (last[i] & (owner_q == PW'(i)));
         sel_x    = sel_x    | (x_in[6*i +: 6]    & {6{owner_q == PW'(i)}});
         sel_y    = sel_y    | (y_in[6*i +: 6]    & {6{owner_q == PW'(i)}});
         sel_char = sel_char | (char_in[6*i +: 6] & {6{owner_q == PW'(i)}});
      end
      in_range = ({1'b0, sel_x} < COLS_L) && ({1'b0, sel_y} < ROWS_L);
      next_rr  = (owner_q == LAST_OWNER) ? {PW{1'b0}} : owner_q + PW'(1);
   end

   // Round-robin search: lowest requesting lane at or above rr_ptr wins,
   // otherwise the lowest requesting lane below it (wrap-around).
   always_comb begin
      pick_lo  = {PW{1'b0}};
      pick_hi  = {PW{1'b0}};
      found_hi = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         pick_lo  = (req[i] && (PW'(i) <  rr_ptr_q)) ? PW'(i) : pick_lo;
         pick_hi  = (req[i] && (PW'(i) >= rr_ptr_q)) ? PW'(i) : pick_hi;
         found_hi = found_hi | (req[i] && (PW'(i) >= rr_ptr_q));
      end
      pick       = found_hi ? pick_hi : pick_lo;
      pick_valid = |req;
   end

`ifdef FRAME_ARB_CLEAR_EN
   // Clear request qualification; a request seen during a burst waits for its end.
   always_comb begin
      clear_go = clear_start | clr_pend_q;
      clr_last = (clr_x_q == LAST_X) && (clr_y_q == LAST_Y);
   end
`else
   // No clear sequencer in this build.
   always_comb begin
      clear_go = 1'b0;
   end
`endif

   // Next-state logic, ownership and burst bookkeeping.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
`ifdef FRAME_ARB_CLEAR_EN
      clr_x_d    = clr_x_q;
      clr_y_d    = clr_y_q;
      clr_pend_d = clr_pend_q;
`endif
      case (state_q)
         S_IDLE: begin
            beat_cnt_d = 8'd0;
            if (clear_go) begin
               state_d = S_CLEAR;
            end else if (pick_valid) begin
               state_d = S_LOCK;
               owner_d = pick;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOCK: begin
            // Owner dropped its request, flagged last, or hit the burst cap.
            if (!sel_req || sel_last || (beat_cnt_q + 8'd1 == MAX_B)) begin
               state_d    = S_IDLE;
               rr_ptr_d   = next_rr;
               beat_cnt_d = 8'd0;
            end else begin
               beat_cnt_d = beat_cnt_q + 8'd1;
            end
         end
`ifdef FRAME_ARB_CLEAR_EN
         S_CLEAR: begin
            if (clr_x_q == LAST_X) begin
               clr_x_d = 6'd0;
               if (clr_y_q == LAST_Y) begin
                  clr_y_d = 6'd0;
                  state_d = S_IDLE;
               end else begin
                  clr_y_d = clr_y_q + 6'd1;
               end
            end else begin
               clr_x_d = clr_x_q + 6'd1;
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase
`ifdef FRAME_ARB_CLEAR_EN
      if (state_q == S_IDLE) begin
         clr_pend_d = 1'b0;
      end else if ((state_q == S_LOCK) && clear_start) begin
         clr_pend_d = 1'b1;
      end else begin
         clr_pend_d = clr_pend_q;
      end
`endif
   end

   // Output logic: grant decode and next value of the registered write bus.
   always_comb begin
      frame_x_d    = frame_x_q;
      frame_y_d    = frame_y_q;
      frame_char_d = frame_char_q;
      frame_we_d   = 1'b0;
      range_err_d  = 1'b0;
      // Grant is withheld during reset so a requester keeps its beat.
      if ((state_q == S_LOCK) && !reset) begin
         grant_s = ({{(N-1){1'b0}}, 1'b1} << owner_q) & req;
      end else begin
         grant_s = {N{1'b0}};
      end
      if ((state_q == S_LOCK) && sel_req) begin
         if (in_range) begin
            frame_x_d    = sel_x;
            frame_y_d    = sel_y;
            frame_char_d = sel_char;
            frame_we_d   = 1'b1;
         end else begin
            range_err_d  = 1'b1;
         end
      end else begin
         frame_we_d = 1'b0;
      end
`ifdef FRAME_ARB_CLEAR_EN
      if (state_q == S_CLEAR) begin
         frame_x_d    = clr_x_q;
         frame_y_d    = clr_y_q;
         frame_char_d = BLANK_CHAR;
         frame_we_d   = 1'b1;
         clear_done_d = clr_last;
      end else begin
         clear_done_d = 1'b0;
      end
`endif
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
`ifdef FRAME_ARB_CLEAR_EN
         state_q      <= S_CLEAR;
         clr_x_q      <= 6'd0;
         clr_y_q      <= 6'd0;
         clr_pend_q   <= 1'b0;
         clear_done_q <= 1'b0;
`else
         state_q      <= S_IDLE;
`endif
         owner_q      <= {PW{1'b0}};
         rr_ptr_q     <= {PW{1'b0}};
         beat_cnt_q   <= 8'd0;
         frame_x_q    <= 6'd0;
         frame_y_q    <= 6'd0;
         frame_char_q <= 6'd0;
         frame_we_q   <= 1'b0;
         range_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
`ifdef FRAME_ARB_CLEAR_EN
         clr_x_q      <= clr_x_d;
         clr_y_q      <= clr_y_d;
         clr_pend_q   <= clr_pend_d;
         clear_done_q <= clear_done_d;
`endif
         owner_q      <= owner_d;
         rr_ptr_q     <= rr_ptr_d;
         beat_cnt_q   <= beat_cnt_d;
         frame_x_q    <= frame_x_d;
         frame_y_q    <= frame_y_d;
         frame_char_q <= frame_char_d;
         frame_we_q   <= frame_we_d;
         range_err_q  <= range_err_d;
      end
   end

   assign grant      = grant_s;
   assign frame_x    = frame_x_q;
   assign frame_y    = frame_y_q;
   assign frame_char = frame_char_q;
   assign frame_we   = frame_we_q;
   assign range_err  = range_err_q;
   assign busy       = (state_q != S_IDLE);
`ifdef FRAME_ARB_CLEAR_EN
   assign clear_done = clear_done_q;
`endif

endmodule

// File: tb/tb_frame_write_arbiter.sv
// Bench for frame_write_arbiter (N=3, 40x30 screen, burst cap of 4).
// A table of per-cycle vectors drives the requesters and carries the
// expected grant/busy; accepted beats push their expected frame write into
// a queue that is popped one cycle later. Reset mid-burst and the optional
// clear sequence are written out by hand.
module tb_frame_write_arbiter;

   typedef struct {
      logic [2:0]  req;
      logic [2:0]  last;
      logic [17:0] x;
      logic [17:0] y;
      logic [17:0] c;
      logic [2:0]  eg;
      logic        eb;
   } vec_t;

   typedef struct {
      logic       we;
      logic       err;
      logic [5:0] x;
      logic [5:0] y;
      logic [5:0] c;
   } exp_t;

`ifdef FRAME_ARB_CLEAR_EN
   localparam logic BUSY_AFTER_RST = 1'b1;
`else
   localparam logic BUSY_AFTER_RST = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  req, last;
   logic [17:0] x_in, y_in, char_in;
   logic [2:0]  grant;
   logic [5:0]  frame_x, frame_y, frame_char;
   logic        frame_we, busy, range_err;
`ifdef FRAME_ARB_CLEAR_EN
   logic        clear_start, clear_done;
`endif

   int   n_checks = 0;
   int   n_errors = 0;
   vec_t tbl[$];
   exp_t sbq[$];

   frame_write_arbiter #(
      .N(3), .COLS(40), .ROWS(30), .MAX_BURST(4), .BLANK_CHAR(6'd0)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .last(last),
      .x_in(x_in), .y_in(y_in), .char_in(char_in), .grant(grant),
      .frame_x(frame_x), .frame_y(frame_y), .frame_char(frame_char),
      .frame_we(frame_we), .busy(busy), .range_err(range_err)
`ifdef FRAME_ARB_CLEAR_EN
      , .clear_start(clear_start), .clear_done(clear_done)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] r, input logic [2:0] l,
                               input logic [2:0] g, input logic b, input int k);
      vec_t v;
      v.req = r; v.last = l; v.eg = g; v.eb = b;
      for (int i = 0; i < 3; i++) begin
         v.x[6*i +: 6] = 6'((k + i) % 40);
         v.y[6*i +: 6] = 6'((k + 2*i) % 30);
         v.c[6*i +: 6] = 6'((3*k + i) % 64);
      end
      return v;
   endfunction

   task automatic add(input logic [2:0] r, input logic [2:0] l, input logic [2:0] g, input logic b);
      tbl.push_back(mk(r, l, g, b, tbl.size()));
   endtask

   // Same as add, with requester 0's coordinates forced.
   task automatic add_r(input logic [2:0] r, input logic [2:0] l, input logic [2:0] g,
                        input logic b, input logic [5:0] x0, input logic [5:0] y0);
      vec_t v;
      v = mk(r, l, g, b, tbl.size());
      v.x[5:0] = x0;
      v.y[5:0] = y0;
      tbl.push_back(v);
   endtask

   // Compare the registered write bus with the oldest expected write.
   task automatic check_out(input string tag);
      exp_t e;
      if (sbq.size() > 0) e = sbq.pop_front();
      else e = '{we: 1'b0, err: 1'b0, x: 6'd0, y: 6'd0, c: 6'd0};
      chk($sformatf("%s_we", tag), frame_we, e.we);
      chk($sformatf("%s_rerr", tag), range_err, e.err);
      if (e.we) begin
         chk($sformatf("%s_x", tag), frame_x, e.x);
         chk($sformatf("%s_y", tag), frame_y, e.y);
         chk($sformatf("%s_char", tag), frame_char, e.c);
      end
   endtask

   task automatic drive_cycle(input vec_t v, input string tag);
      exp_t e;
      int   o;
      @(negedge clk);
      req = v.req; last = v.last; x_in = v.x; y_in = v.y; char_in = v.c;
      #1;
      chk($sformatf("%s_grant", tag), grant, v.eg);
      chk($sformatf("%s_busy", tag), busy, v.eb);
      check_out(tag);
      if ((v.eg & v.req) != 3'b000) begin
         o = 0;
         for (int i = 0; i < 3; i++) if (v.eg[i]) o = i;
         e.x   = v.x[6*o +: 6];
         e.y   = v.y[6*o +: 6];
         e.c   = v.c[6*o +: 6];
         e.err = (e.x >= 6'd40) || (e.y >= 6'd30);
         e.we  = !e.err;
         sbq.push_back(e);
      end
   endtask

   // Release reset and check the reset state; with the clear feature, also
   // follow the whole clear sequence while requester 0 is held requesting.
   task automatic post_reset_check(input string tag);
      @(negedge clk);
      reset = 1'b0; last = 3'b000;
`ifdef FRAME_ARB_CLEAR_EN
      req = 3'b001;
`else
      req = 3'b000;
`endif
      #1;
      sbq.delete();
      chk($sformatf("%s_grant", tag), grant, 3'b000);
      chk($sformatf("%s_busy", tag), busy, BUSY_AFTER_RST);
      chk($sformatf("%s_we", tag), frame_we, 1'b0);
      chk($sformatf("%s_rerr", tag), range_err, 1'b0);
      chk($sformatf("%s_x", tag), frame_x, 6'd0);
      chk($sformatf("%s_y", tag), frame_y, 6'd0);
      chk($sformatf("%s_char", tag), frame_char, 6'd0);
`ifdef FRAME_ARB_CLEAR_EN
      chk($sformatf("%s_cdone", tag), clear_done, 1'b0);
      for (int k = 0; k < 1200; k++) begin
         @(negedge clk);
         req = (k < 1199) ? 3'b001 : 3'b000;
         #1;
         chk($sformatf("%s_clr%0d_grant", tag, k), grant, 3'b000);
         chk($sformatf("%s_clr%0d_we", tag, k), frame_we, 1'b1);
         chk($sformatf("%s_clr%0d_x", tag, k), frame_x, k % 40);
         chk($sformatf("%s_clr%0d_y", tag, k), frame_y, k / 40);
         chk($sformatf("%s_clr%0d_char", tag, k), frame_char, 6'd0);
         chk($sformatf("%s_clr%0d_done", tag, k), clear_done, (k == 1199) ? 1'b1 : 1'b0);
      end
      @(negedge clk);
      #1;
      chk($sformatf("%s_clr_end_we", tag), frame_we, 1'b0);
      chk($sformatf("%s_clr_end_done", tag), clear_done, 1'b0);
      chk($sformatf("%s_clr_end_busy", tag), busy, 1'b0);
`endif
   endtask

   initial begin
      reset = 1'b1; req = 3'b000; last = 3'b000;
      x_in = 18'd0; y_in = 18'd0; char_in = 18'd0;
`ifdef FRAME_ARB_CLEAR_EN
      clear_start = 1'b0;
`endif
      repeat (3) @(negedge clk);
      post_reset_check("rst");

      // Single owner, 3-beat burst.
      add(3'b001, 3'b000, 3'b000, 1'b0);
      add(3'b001, 3'b000, 3'b001, 1'b1);
      add(3'b001, 3'b000, 3'b001, 1'b1);
      add(3'b001, 3'b001, 3'b001, 1'b1);
      add(3'b000, 3'b000, 3'b000, 1'b0);
      // Round-robin, single-beat bursts; pointer starts at 1 after owner 0.
      for (int r = 0; r < 2; r++) begin
         add(3'b111, 3'b111, 3'b000, 1'b0);
         add(3'b111, 3'b111, 3'b010, 1'b1);
         add(3'b111, 3'b111, 3'b000, 1'b0);
         add(3'b111, 3'b111, 3'b100, 1'b1);
         add(3'b111, 3'b111, 3'b000, 1'b0);
         add(3'b111, 3'b111, 3'b001, 1'b1);
      end
      add(3'b000, 3'b000, 3'b000, 1'b0);
      // Burst cap of 4 on requester 1, then requester 2 takes over.
      add(3'b110, 3'b000, 3'b000, 1'b0);
      for (int b = 0; b < 4; b++) add(3'b110, 3'b000, 3'b010, 1'b1);
      add(3'b110, 3'b000, 3'b000, 1'b0);
      add(3'b110, 3'b100, 3'b100, 1'b1);
      add(3'b000, 3'b000, 3'b000, 1'b0);
      // Range check: x off-screen, y off-screen, then the far corner.
      add_r(3'b001, 3'b000, 3'b000, 1'b0, 6'd40, 6'd5);
      add_r(3'b001, 3'b000, 3'b001, 1'b1, 6'd40, 6'd5);
      add_r(3'b001, 3'b000, 3'b001, 1'b1, 6'd0,  6'd30);
      add_r(3'b001, 3'b001, 3'b001, 1'b1, 6'd39, 6'd29);
      add(3'b000, 3'b000, 3'b000, 1'b0);
      add(3'b000, 3'b000, 3'b000, 1'b0);

      for (int k = 0; k < tbl.size(); k++) drive_cycle(tbl[k], $sformatf("v%0d", k));

      // Reset during requester 1's second beat.
      drive_cycle(mk(3'b010, 3'b000, 3'b000, 1'b0, 50), "t5_idle");
      drive_cycle(mk(3'b010, 3'b000, 3'b010, 1'b1, 51), "t5_beat1");
      @(negedge clk);
      reset = 1'b1; req = 3'b010;
      #1;
      check_out("t5_rstcyc");
      post_reset_check("t5");
      drive_cycle(mk(3'b000, 3'b000, 3'b000, 1'b0, 52), "t5_after");
      chk("t5_sb_empty", sbq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
